queue_occupancy_counter: RTL
============================

// Module: queue_occupancy_counter
//
// PURPOSE
//   Clocked, parametrised occupancy counter for the bank queue.
//   Tracks the number of customers between the entry sensor (arrive) and the
//   teller sensor (depart), saturating at 0 and MAX_COUNT.
//   Drives empty / almost_full / full status and sticky overflow / underflow
//   error flags. Feeds the display and wait-time logic downstream.
//
// PARAMETERS
//   WIDTH        3  counter width in bits
//   MAX_COUNT    7  saturation ceiling; 1 <= MAX_COUNT <= 2**WIDTH-1
//   ALMOST_FULL  6  almost_full threshold; 0 < ALMOST_FULL <= MAX_COUNT
//
// PORTS
//   clk            input   1      system clock; all state updates on posedge
//   reset          input   1      reset, asynchronous, active-low
//   arrive         input   1      entry sensor level; a rising edge = one arrival
//   depart         input   1      teller sensor level; a rising edge = one departure
//   err_clr        input   1      synchronous clear of both sticky error flags
//   count          output  WIDTH  current occupancy
//   empty          output  1      count == 0
//   almost_full    output  1      count >= ALMOST_FULL
//   full           output  1      count == MAX_COUNT
//   overflow_err   output  1      sticky; an arrival was rejected while full
//   underflow_err  output  1      sticky; a departure was rejected while empty
//
// BEHAVIOUR
//   - Reset (reset=0, async assert, sync release):
//     - count=0, empty=1, almost_full=0, full=0, both error flags=0.
//     - Edge-detect history registers clear to 0, so a sensor already high at
//       release counts as one edge on the first clock.
//   - Edge detect:
//     - arr_p = arrive_s & ~arrive_q; dep_p = depart_s & ~depart_q.
//     - *_s is the (optionally synchronised) sensor; *_q is its value at the
//       previous clock.
//     - A held-high level counts once only.
//   - Update rules, evaluated each clock:
//     - arr_p & !dep_p & count <  MAX_COUNT : count+1
//     - arr_p & !dep_p & count == MAX_COUNT : hold; overflow_err <= 1
//     - dep_p & !arr_p & count >  0         : count-1
//     - dep_p & !arr_p & count == 0         : hold; underflow_err <= 1
//     - arr_p & dep_p                       : hold, any count, no error
//     - neither pulse                       : hold
//   - No wrap-around: saturation is mandatory. Arithmetic is WIDTH bits unsigned.
//   - Latency:
//     - An edge first sampled at clock k updates count at clock k.
//     - The new value is visible after edge k.
//     - Flags are registered and update on the same edge as count.
//   - err_clr:
//     - Clears both error flags at the next edge.
//     - If an error event occurs in the same cycle, the set wins.
//   - Reset mid-operation: all state is discarded; no edge is pending afterwards.
//
// CONFIGURATION
//   QOCC_SYNC_EN defined:
//     - arrive and depart each pass through a 2-flop synchroniser (reset to 0)
//       before edge detection.
//     - An edge sampled at clock k updates count at clock k+2.
//     - The sensors may be fully asynchronous to clk.
//   QOCC_SYNC_EN undefined:
//     - *_s = raw input; latency as in BEHAVIOUR.
//     - Inputs must be synchronous to clk.
//
// TESTING  (defaults WIDTH=3, MAX_COUNT=7, ALMOST_FULL=6, no sync)
//   1. Reset, then 3 arrive pulses -> count=3, empty=0, almost_full=0, full=0.
//   2. 8 arrive pulses from 0 -> count saturates at 7, full=1, almost_full=1,
//      overflow_err=1; count=6 seen after the 6th pulse with almost_full=1.
//   3. depart pulse at count=0 -> count stays 0, underflow_err=1;
//      err_clr for 1 cycle -> underflow_err=0.
//   4. arrive and depart rising in the same cycle at count=4 -> count stays 4,
//      no error; arrive held high 10 cycles -> +1 only.
//   5. Assert reset low mid-burst at count=5 -> count=0 and all flags at reset
//      values immediately, without waiting for a clock.
//   6. With QOCC_SYNC_EN, an arrive edge sampled at clock k -> count changes
//      after edge k+2, not earlier.

Source files
------------

// File: rtl/queue_occupancy_counter_if.sv
// Sensor inputs and status outputs of the bank-queue occupancy counter.
// The sensor side is the master; the counter is the slave.
interface queue_occupancy_counter_if #(
   parameter int WIDTH = 3
);
   logic             arrive;
   logic             depart;
   logic             err_clr;
   logic [WIDTH-1:0] count;
   logic             empty;
   logic             almost_full;
   logic             full;
   logic             overflow_err;
   logic             underflow_err;

   modport master (
      output arrive, depart, err_clr,
      input  count, empty, almost_full, full, overflow_err, underflow_err
   );

   modport slave (
      input  arrive, depart, err_clr,
      output count, empty, almost_full, full, overflow_err, underflow_err
   );
endinterface

// File: rtl/queue_occupancy_counter.sv
// Saturating bank-queue occupancy counter with registered status and sticky error flags.
// Define QOCC_SYNC_EN to put a 2-flop synchroniser on arrive/depart (adds 2 clocks of latency).
module queue_occupancy_counter #(
   parameter int WIDTH       = 3,
   parameter int MAX_COUNT   = 7,
   parameter int ALMOST_FULL = 6
) (
   input  logic                       clk,
   input  logic                       reset,
   queue_occupancy_counter_if.slave   q
);
   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);
   localparam logic [WIDTH-1:0] AF_C  = WIDTH'(ALMOST_FULL);

   logic arrive_s, depart_s;

`ifdef QOCC_SYNC_EN
   logic [1:0] arr_sync_q, dep_sync_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         arr_sync_q <= '0;
         dep_sync_q <= '0;
      end else begin
         arr_sync_q <= {arr_sync_q[0], q.arrive};
         dep_sync_q <= {dep_sync_q[0], q.depart};
      end
   end

   assign arrive_s = arr_sync_q[1];
   assign depart_s = dep_sync_q[1];
`else
   assign arrive_s = q.arrive;
   assign depart_s = q.depart;
`endif

   logic             arrive_q, depart_q;
   logic [WIDTH-1:0] count_q, count_d;
   logic             empty_q, empty_d;
   logic             af_q, af_d;
   logic             full_q, full_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             arr_p, dep_p, ovf_evt, unf_evt;

   always_comb begin
      arr_p   = arrive_s & ~arrive_q;
      dep_p   = depart_s & ~depart_q;
      count_d = count_q;
      ovf_evt = 1'b0;
      unf_evt = 1'b0;
      // Simultaneous arrival and departure cancel out, even at the limits.
      if (arr_p && !dep_p) begin
         if (count_q < MAX_C) count_d = count_q + 1'b1;
         else                 ovf_evt = 1'b1;
      end else if (dep_p && !arr_p) begin
         if (count_q != '0)   count_d = count_q - 1'b1;
         else                 unf_evt = 1'b1;
      end
      ovf_d   = ovf_evt | (ovf_q & ~q.err_clr);
      unf_d   = unf_evt | (unf_q & ~q.err_clr);
      empty_d = (count_d == '0);
      af_d    = (count_d >= AF_C);
      full_d  = (count_d == MAX_C);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         arrive_q <= 1'b0;
         depart_q <= 1'b0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         af_q     <= 1'b0;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         arrive_q <= arrive_s;
         depart_q <= depart_s;
         count_q  <= count_d;
         empty_q  <= empty_d;
         af_q     <= af_d;
         full_q   <= full_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   assign q.count         = count_q;
   assign q.empty         = empty_q;
   assign q.almost_full   = af_q;
   assign q.full          = full_q;
   assign q.overflow_err  = ovf_q;
   assign q.underflow_err = unf_q;
endmodule
